// File: rtl/tag_resolver.sv
// tag_resolver: snapshots a tag vector and emits set-bit indices lowest first; TAG_RESOLVER_COUNT_EN adds a popcount
module tag_resolver #(
  parameter int DATA_DEPTH = 128,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_DEPTH-1:0] tag_in,
  input  logic                  tag_load,
  output logic                  busy,
  output logic                  row_valid,
  input  logic                  row_ready,
  output logic [ADDR_WIDTH-1:0] row_addr,
  output logic                  done,
  output logic                  any_match,
  output logic [ADDR_WIDTH:0]   match_count
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state;
  logic [DATA_DEPTH-1:0] pending, nxt;
  function automatic logic [ADDR_WIDTH-1:0] pe(input logic [DATA_DEPTH-1:0] v);
    pe = '0;
    for (int i = DATA_DEPTH - 1; i >= 0; i--)
      if (v[i]) pe = ADDR_WIDTH'(i);
  endfunction
  always_comb begin
    nxt = pending;
    nxt[row_addr] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      row_valid <= 1'b0;
      row_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      any_match <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (tag_load) begin
          pending   <= tag_in;
          row_addr  <= pe(tag_in);
          row_valid <= |tag_in;
          any_match <= |tag_in;
          busy      <= 1'b1;
          done      <= ~|tag_in;
          state     <= |tag_in ? SCAN : DONE;
        end
        SCAN: if (row_valid && row_ready) begin
          pending   <= nxt;
          row_addr  <= pe(nxt);
          row_valid <= |nxt;
          done      <= ~|nxt;
          state     <= |nxt ? SCAN : DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
`ifdef TAG_RESOLVER_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) match_count <= '0;
    else if (state == IDLE && tag_load) match_count <= (ADDR_WIDTH+1)'($countones(tag_in));
  end
`else
  assign match_count = '0;
`endif
endmodule

// File: tb/tb_tag_resolver.sv
// tb_tag_resolver: directed and randomized checks of tag_resolver against a queue-based model
module tb_tag_resolver;
  localparam int DD = 128;
  localparam int AW = 7;
`ifdef TAG_RESOLVER_COUNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, tag_load = 1'b0, row_ready = 1'b0;
  logic [DD-1:0] tag_in = '0;
  logic busy, row_valid, done, any_match;
  logic [AW-1:0] row_addr;
  logic [AW:0] match_count;
  int tests = 0, fails = 0;
  int mq[$];
  int ms = 0, mcnt = 0;
  bit many = 0, started = 0;
  tag_resolver #(.DATA_DEPTH(DD), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .tag_in(tag_in), .tag_load(tag_load), .busy(busy),
    .row_valid(row_valid), .row_ready(row_ready), .row_addr(row_addr), .done(done),
    .any_match(any_match), .match_count(match_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // ms: 0 idle, 1 emitting mq front, 2 done pulse
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      ms = 0;
      many = 0;
      mcnt = 0;
    end else if (ms == 0) begin
      if (tag_load) begin
        mq.delete();
        for (int i = 0; i < DD; i++) if (tag_in[i]) mq.push_back(i);
        many = mq.size() != 0;
        mcnt = CNT ? mq.size() : 0;
        ms = many ? 1 : 2;
      end
    end else if (ms == 1) begin
      if (row_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) ms = 2;
      end
    end else ms = 0;
    started = 1;
  end
  always @(negedge clk) if (started) begin
    check("busy", busy, 32'(ms != 0));
    check("row_valid", row_valid, 32'(ms == 1));
    if (ms == 1) check("row_addr", row_addr, mq[0]);
    check("done", done, 32'(ms == 2));
    check("any_match", any_match, 32'(many));
    check("match_count", match_count, mcnt);
  end
  task automatic load(input logic [DD-1:0] v);
    tag_in = v;
    tag_load = 1'b1;
    @(negedge clk);
    tag_load = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle timeout", busy, 0);
    @(negedge clk);
  endtask
  function automatic logic [DD-1:0] bits3(input int a, input int b, input int c);
    logic [DD-1:0] v = '0;
    v[a] = 1'b1;
    v[b] = 1'b1;
    v[c] = 1'b1;
    return v;
  endfunction
  initial begin
    logic [DD-1:0] v;
    repeat (2) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst row_valid", row_valid, 0);
    check("rst row_addr", row_addr, 0);
    check("rst done", done, 0);
    check("rst any_match", any_match, 0);
    check("rst match_count", match_count, 0);
    rst = 1'b0;
    row_ready = 1'b1;
    load(bits3(0, 5, 127));
    check("sparse r0", row_addr, 0);
    check("sparse any", any_match, 1);
    check("sparse cnt", match_count, CNT ? 3 : 0);
    @(negedge clk);
    check("sparse r1", row_addr, 5);
    @(negedge clk);
    check("sparse r2", row_addr, 127);
    check("sparse v2", row_valid, 1);
    @(negedge clk);
    check("sparse done", done, 1);
    check("sparse v3", row_valid, 0);
    @(negedge clk);
    check("sparse done off", done, 0);
    check("sparse idle", busy, 0);
    load(DD'(8'hFF));
    @(negedge clk);
    @(negedge clk);
    check("midscan r2", row_addr, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midscan rst valid", row_valid, 0);
    check("midscan rst busy", busy, 0);
    check("midscan rst addr", row_addr, 0);
    check("midscan rst any", any_match, 0);
    load(DD'(8));
    check("after rst r", row_addr, 3);
    check("after rst v", row_valid, 1);
    wait_idle();
    row_ready = 1'b0;
    load(bits3(2, 9, 9));
    for (int i = 0; i < 3; i++) begin
      check("bp hold addr", row_addr, 2);
      check("bp hold valid", row_valid, 1);
      @(negedge clk);
    end
    row_ready = 1'b1;
    @(negedge clk);
    check("bp r1", row_addr, 9);
    @(negedge clk);
    check("bp done", done, 1);
    wait_idle();
    load('0);
    check("empty done", done, 1);
    check("empty valid", row_valid, 0);
    check("empty busy", busy, 1);
    check("empty any", any_match, 0);
    check("empty cnt", match_count, 0);
    @(negedge clk);
    check("empty done off", done, 0);
    check("empty idle", busy, 0);
    load(DD'(18));
    check("busyload r0", row_addr, 1);
    tag_in = '1;
    tag_load = 1'b1;
    @(negedge clk);
    check("busyload r1", row_addr, 4);
    @(negedge clk);
    tag_load = 1'b0;
    check("busyload done", done, 1);
    check("busyload cnt", match_count, CNT ? 2 : 0);
    wait_idle();
    load('1);
    for (int i = 0; i < DD; i++) begin
      check("full addr", row_addr, i);
      @(negedge clk);
    end
    check("full done", done, 1);
    check("full cnt", match_count, CNT ? 128 : 0);
    wait_idle();
    for (int n = 0; n < 1500; n++) begin
      row_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 99) == 0;
      tag_load = $urandom_range(0, 3) == 0;
      case ($urandom_range(0, 9))
        0: v = '0;
        1: v = '1;
        default: begin
          for (int k = 0; k < DD / 32; k++) v[k*32 +: 32] = $urandom() & $urandom() & $urandom();
        end
      endcase
      tag_in = v;
      @(negedge clk);
    end
    rst = 1'b0;
    tag_load = 1'b0;
    row_ready = 1'b1;
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tag_resolver.md
Name: tag_resolver

Overview:
- Consumer (reader) side of the tag vector. Takes a snapshot of a DATA_DEPTH-bit match-tag vector produced by the tag stage.
- Emits the index of each set bit in turn, lowest index first, one index per accepted handshake.
- Feeds the row-sequential write-back and readout logic, which serves one tagged row at a time.

Parameters:
- DATA_DEPTH, 128, number of rows (tag vector width); must be a power of two, at least 2.
- ADDR_WIDTH, 7, row index width; equals log2(DATA_DEPTH).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- tag_in  input  DATA_DEPTH  tag vector to resolve; sampled only on an accepted load.
- tag_load  input  1  request to snapshot tag_in; accepted only in IDLE.
- busy  output  1  high in SCAN and DONE.
- row_valid  output  1  row_addr holds a pending tagged row.
- row_ready  input  1  consumer accepts row_addr this cycle.
- row_addr  output  ADDR_WIDTH  index of the lowest remaining set bit.
- done  output  1  one-cycle pulse when the snapshot is exhausted.
- any_match  output  1  snapshot had at least one bit set; held until the next accepted load.
- match_count  output  ADDR_WIDTH+1  population count of the snapshot.

Behaviour:
- Reset (rst=1 at a clock edge), from any state including mid-scan:
  - state=IDLE; pending=0.
  - row_valid=0, row_addr=0, busy=0, done=0, any_match=0, match_count=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- IDLE:
  - If tag_load=1: pending<=tag_in; row_addr<=pe(tag_in); row_valid<=|tag_in; any_match<=|tag_in; busy<=1.
  - Next state is SCAN if tag_in is non-zero, else DONE.
  - pe() is a lowest-set-bit priority encoder.
- Latency: load accepted at edge N gives the first row_valid=1 after edge N.
- SCAN:
  - Handshake is row_valid & row_ready at a clock edge.
  - On handshake: pending_next = pending with bit row_addr cleared; pending<=pending_next; row_addr<=pe(pending_next); row_valid<=|pending_next.
  - If pending_next==0, go to DONE.
  - With row_ready held high, one index is emitted per cycle with no bubbles.
  - While row_ready=0: row_addr, row_valid and pending are held stable.
- DONE:
  - done=1 for exactly one cycle; row_valid=0; busy=1 during this cycle.
  - Next state is IDLE; busy=0 from then on.
- Zero tag vector: IDLE -> DONE -> IDLE. done pulses at N+1 and row_valid never rises.
- tag_load outside IDLE is ignored and does not affect the snapshot.
- tag_load in the same cycle as the final handshake is ignored; the load must be reissued after busy=0.
- pe(0)=0, but row_addr is only meaningful when row_valid=1.
- match_count may reach DATA_DEPTH (128 needs 8 bits), so it is ADDR_WIDTH+1 bits wide.

Optional Feature:
- Macro: TAG_RESOLVER_COUNT_EN.
- Defined: a popcount of tag_in is registered into match_count on each accepted load and held until the next accepted load or reset.
- Not defined: no popcount logic is built; match_count is tied to 0.
- All other ports and behaviour are identical in both builds.

Test Plan:
- Reset mid-scan: load 0xFF, accept 2 rows, then assert rst for 1 cycle -> all outputs 0 and state IDLE. A new load of bit 3 only yields row_addr=3.
- Sparse vector: tag_in = bits {0,5,127}, row_ready=1 -> row_addr 0, 5, 127 on consecutive cycles after the load. done pulses the cycle after 127 is accepted. any_match=1; match_count=3 when TAG_RESOLVER_COUNT_EN is defined.
- Backpressure: tag_in = bits {2,9}, row_ready=0 for 3 cycles -> row_addr=2 with row_valid=1 held stable for 3 cycles. Raising row_ready then gives 9, then done.
- Empty vector: load tag_in=0 -> done=1 exactly one cycle after the load, row_valid stays 0, any_match=0, match_count=0.
- Load while busy: during a scan of {1,4}, pulse tag_load with tag_in=all-ones -> only 1 and 4 are emitted. match_count stays 2 (COUNT_EN) or 0 (no COUNT_EN).
- Full vector: tag_in=all-ones, row_ready=1 -> indices 0..127 in order over 128 cycles. match_count=128 with COUNT_EN.
